// File: rtl/sync10010_pkg.sv
// sync10010_pkg: sync word, frame FSM encoding and sync-bit lookup shared by the
// 10010 transmitter and detector.
package sync10010_pkg;
   localparam logic [4:0] SYNC_WORD = 5'b10010;
   localparam int SYNC_LEN = 5;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      GAP    = 3'd4
   } state_t;
   function automatic logic sync_bit(input logic [2:0] k);
      logic [2:0] b;
      b = 3'(SYNC_LEN - 1) - k;
      return SYNC_WORD[b];
   endfunction
endpackage

// File: rtl/sync10010_bit_timer.sv
// sync10010_bit_timer: counts BIT_CYCLES clocks per serial bit and flags the
// last clock of each bit period; held at zero while i_clr is high.
module sync10010_bit_timer #(
   parameter int BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_bit_end
);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   logic [CW-1:0] r_cnt;
   assign o_bit_end = (r_cnt == CW'(BIT_CYCLES - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else     r_cnt <= (i_clr || o_bit_end) ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/sync10010_tx.sv
// sync10010_tx: serializes handshaken payload words as 10010-sync frames with
// MSB-first data, even parity and a zero gap; j is registered.
module sync10010_tx
   import sync10010_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_BITS   = 2,
   parameter int BIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              j,
   output logic              busy,
   output logic              frame_start,
   output logic              frame_done
);
   localparam int MAXN = (DATA_W > GAP_BITS) ? ((DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN)
                                             : ((GAP_BITS > SYNC_LEN) ? GAP_BITS : SYNC_LEN);
   localparam int IW = $clog2(MAXN + 1);

   state_t            r_state, w_state_nxt;
   logic [IW-1:0]     r_idx, w_idx_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic              r_par, r_j, r_busy, r_start;
   logic              w_take, w_bit_end, w_done, w_j_nxt;

   sync10010_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state == IDLE),
      .o_bit_end (w_bit_end)
   );

   assign w_take = (r_state == IDLE) && tx_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_done      = 1'b0;
      case (r_state)
         IDLE: if (w_take) begin
            w_state_nxt = SYNC;
            w_idx_nxt   = '0;
            w_shift_nxt = tx_data;
         end
         SYNC: if (w_bit_end) begin
            w_state_nxt = (r_idx == IW'(SYNC_LEN - 1)) ? DATA : SYNC;
            w_idx_nxt   = (r_idx == IW'(SYNC_LEN - 1)) ? '0 : r_idx + IW'(1);
         end
         DATA: if (w_bit_end) begin
            w_state_nxt = (r_idx == IW'(DATA_W - 1)) ? PARITY : DATA;
            w_idx_nxt   = (r_idx == IW'(DATA_W - 1)) ? '0 : r_idx + IW'(1);
            w_shift_nxt = r_shift << 1;
         end
         PARITY: if (w_bit_end) begin
            w_state_nxt = (GAP_BITS == 0) ? IDLE : GAP;
            w_idx_nxt   = '0;
            w_done      = (GAP_BITS == 0);
         end
         GAP: if (w_bit_end) begin
            w_state_nxt = (r_idx == IW'(GAP_BITS - 1)) ? IDLE : GAP;
            w_idx_nxt   = (r_idx == IW'(GAP_BITS - 1)) ? '0 : r_idx + IW'(1);
            w_done      = (r_idx == IW'(GAP_BITS - 1));
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Line value is derived from the next state so j lines up with the state register.
   assign w_j_nxt = (w_state_nxt == SYNC)   ? sync_bit(3'(w_idx_nxt)) :
                    (w_state_nxt == DATA)   ? w_shift_nxt[DATA_W-1] :
                    (w_state_nxt == PARITY) ? r_par : 1'b0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_j     <= 1'b0;
         r_busy  <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         if (w_take) r_par <= ^tx_data;
         r_j     <= w_j_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_start <= w_take;
      end

   assign tx_ready    = (r_state == IDLE);
   assign j           = r_j;
   assign busy        = r_busy;
   assign frame_start = r_start;
   assign frame_done  = w_done;
endmodule
